// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: FETCH -> EXEC -> (MEM) -> FETCH, HALT absorbing.
// Define LEGV8_COND_BRANCH_EN to decode B.cond against the registered flags.

module legv8_control_fsm #(
    parameter int         CW_W = 25,
    parameter logic [4:0] XZR  = 5'd31
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [4:0]      status,
    output logic [CW_W-1:0] control_word,
    output logic            SL,
    output logic [1:0]      PS,
    output logic [63:0]     literal,
    output logic            halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_RTYPE   = 4'd1,
        C_ITYPE   = 4'd2,
        C_STUR    = 4'd3,
        C_LDUR    = 4'd4,
        C_B       = 4'd5,
        C_CBZ     = 4'd6,
        C_CBNZ    = 4'd7,
        C_BR      = 4'd8,
        C_BCOND   = 4'd9,
        C_HALT    = 4'd10
    } op_class_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;

    function automatic logic [63:0] sext_b26(input logic [25:0] imm);
        return {{36{imm[25]}}, imm, 2'b00};
    endfunction

    function automatic logic [63:0] sext_cb19(input logic [18:0] imm);
        return {{43{imm[18]}}, imm, 2'b00};
    endfunction

    function automatic logic [63:0] sext_d9(input logic [8:0] imm);
        return {{55{imm[8]}}, imm};
    endfunction

    // flags = {V,C,N,Z} as presented on status[4:1]
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic v;
        logic c;
        logic n;
        logic z;
        logic res;
        v = flags[3];
        c = flags[2];
        n = flags[1];
        z = flags[0];
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] ir_r;
    op_class_t   dec_class_s;
    op_class_t   op_class_s;
    logic [4:0]  dec_fs_s;
    logic        dec_sl_s;

    logic [4:0]  ex_sa_s, ex_sb_s, ex_da_s, ex_fs_s;
    logic        ex_rw_s, ex_mw_s, ex_bsel_s, ex_enm_s, ex_ena_s, ex_sl_s;
    logic [1:0]  ex_ps_s;
    logic [63:0] ex_lit_s;

    logic [4:0]  sa_s, sb_s, da_s, fs_s;
    logic        rw_s, mw_s, bsel_s, enm_s, ena_s;

    // Opcode classification of the latched instruction
    always_comb begin
        dec_class_s = C_ILLEGAL;
        dec_fs_s    = FS_AND;
        dec_sl_s    = 1'b0;
        casez (ir_r[31:21])
            11'b10001011000: begin dec_class_s = C_RTYPE; dec_fs_s = FS_ADD; end
            11'b10101011000: begin dec_class_s = C_RTYPE; dec_fs_s = FS_ADD; dec_sl_s = 1'b1; end
            11'b11001011000: begin dec_class_s = C_RTYPE; dec_fs_s = FS_SUB; end
            11'b11101011000: begin dec_class_s = C_RTYPE; dec_fs_s = FS_SUB; dec_sl_s = 1'b1; end
            11'b10001010000: begin dec_class_s = C_RTYPE; dec_fs_s = FS_AND; end
            11'b10101010000: begin dec_class_s = C_RTYPE; dec_fs_s = FS_ORR; end
            11'b11001010000: begin dec_class_s = C_RTYPE; dec_fs_s = FS_EOR; end
            11'b1001000100?: begin dec_class_s = C_ITYPE; dec_fs_s = FS_ADD; end
            11'b1101000100?: begin dec_class_s = C_ITYPE; dec_fs_s = FS_SUB; end
            11'b1001001000?: begin dec_class_s = C_ITYPE; dec_fs_s = FS_AND; end
            11'b1011001000?: begin dec_class_s = C_ITYPE; dec_fs_s = FS_ORR; end
            11'b11111000000: dec_class_s = C_STUR;
            11'b11111000010: dec_class_s = C_LDUR;
            11'b000101?????: dec_class_s = C_B;
            11'b10110100???: dec_class_s = C_CBZ;
            11'b10110101???: dec_class_s = C_CBNZ;
            11'b11010110000: dec_class_s = C_BR;
`ifdef LEGV8_COND_BRANCH_EN
            11'b01010100???: dec_class_s = C_BCOND;
`endif
            default:         dec_class_s = C_ILLEGAL;
        endcase
    end

    // An all-zero word halts; it matches no other opcode pattern
    assign op_class_s = (ir_r == 32'd0) ? C_HALT : dec_class_s;

    // EXEC-cycle control fields; branch PS follows status combinationally
    always_comb begin
        ex_sa_s   = 5'd0;
        ex_sb_s   = 5'd0;
        ex_da_s   = 5'd0;
        ex_fs_s   = 5'd0;
        ex_rw_s   = 1'b0;
        ex_mw_s   = 1'b0;
        ex_bsel_s = 1'b0;
        ex_enm_s  = 1'b0;
        ex_ena_s  = 1'b0;
        ex_sl_s   = 1'b0;
        ex_ps_s   = 2'b01;
        ex_lit_s  = 64'd0;
        case (op_class_s)
            C_RTYPE, C_ITYPE: begin
                ex_sa_s   = ir_r[9:5];
                ex_sb_s   = ir_r[20:16];
                ex_da_s   = ir_r[4:0];
                ex_fs_s   = dec_fs_s;
                ex_rw_s   = 1'b1;
                ex_ena_s  = 1'b1;
                ex_sl_s   = dec_sl_s;
                ex_bsel_s = (op_class_s == C_ITYPE);
                ex_lit_s  = (op_class_s == C_ITYPE) ? {52'd0, ir_r[21:10]} : 64'd0;
            end
            C_STUR, C_LDUR: begin
                ex_sa_s   = ir_r[9:5];
                ex_sb_s   = ir_r[4:0];
                ex_fs_s   = FS_ADD;
                ex_bsel_s = 1'b1;
                ex_lit_s  = sext_d9(ir_r[20:12]);
                ex_mw_s   = (op_class_s == C_STUR);
                ex_ps_s   = (op_class_s == C_STUR) ? 2'b01 : 2'b00;
            end
            C_B: begin
                ex_ps_s  = 2'b10;
                ex_lit_s = sext_b26(ir_r[25:0]);
            end
            C_CBZ, C_CBNZ: begin
                ex_sa_s  = XZR;
                ex_sb_s  = ir_r[4:0];
                ex_fs_s  = FS_ADD;
                ex_lit_s = sext_cb19(ir_r[23:5]);
                ex_ps_s  = ((op_class_s == C_CBZ) == status[0]) ? 2'b10 : 2'b01;
            end
            C_BR: begin
                ex_sa_s = ir_r[9:5];
                ex_ps_s = 2'b11;
            end
            C_BCOND: begin
                ex_lit_s = sext_cb19(ir_r[23:5]);
                ex_ps_s  = cond_pass(ir_r[3:0], status[4:1]) ? 2'b10 : 2'b01;
            end
            C_HALT: begin
                ex_ps_s = 2'b00;
            end
            default: begin
                ex_ps_s = 2'b01;
            end
        endcase
    end

    // Next state and state-dependent outputs; reset forces a NOP cycle
    always_comb begin
        next_state_s = state_r;
        sa_s    = 5'd0;
        sb_s    = 5'd0;
        da_s    = 5'd0;
        fs_s    = 5'd0;
        rw_s    = 1'b0;
        mw_s    = 1'b0;
        bsel_s  = 1'b0;
        enm_s   = 1'b0;
        ena_s   = 1'b0;
        SL      = 1'b0;
        PS      = 2'b00;
        literal = 64'd0;
        halted  = 1'b0;
        if (reset) begin
            next_state_s = FETCH;
        end else begin
            case (state_r)
                FETCH: next_state_s = EXEC;
                EXEC: begin
                    sa_s    = ex_sa_s;
                    sb_s    = ex_sb_s;
                    da_s    = ex_da_s;
                    fs_s    = ex_fs_s;
                    rw_s    = ex_rw_s;
                    mw_s    = ex_mw_s;
                    bsel_s  = ex_bsel_s;
                    enm_s   = ex_enm_s;
                    ena_s   = ex_ena_s;
                    SL      = ex_sl_s;
                    PS      = ex_ps_s;
                    literal = ex_lit_s;
                    halted  = (op_class_s == C_HALT);
                    next_state_s = (op_class_s == C_HALT) ? HALT :
                                   (op_class_s == C_LDUR) ? MEM : FETCH;
                end
                MEM: begin
                    sa_s    = ex_sa_s;
                    sb_s    = ex_sb_s;
                    da_s    = ir_r[4:0];
                    fs_s    = ex_fs_s;
                    bsel_s  = ex_bsel_s;
                    literal = ex_lit_s;
                    rw_s    = 1'b1;
                    enm_s   = 1'b1;
                    PS      = 2'b01;
                    next_state_s = FETCH;
                end
                HALT: begin
                    halted       = 1'b1;
                    next_state_s = HALT;
                end
                default: next_state_s = FETCH;
            endcase
        end
    end

    assign control_word = {sa_s, sb_s, da_s, rw_s, mw_s, fs_s, bsel_s, enm_s, ena_s};

    // State and instruction register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FETCH;
            ir_r    <= 32'd0;
        end else begin
            state_r <= next_state_s;
            ir_r    <= (state_r == FETCH) ? instruction : ir_r;
        end
    end

endmodule
